// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_REDIR = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'hE1A0_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_R15_OFS    = 32'd8;

    // Writeback's R15 write outranks a branch resolved in execute.
    function automatic logic [31:0] redirTarget(
        input logic        pcSrcW,
        input logic [31:0] resultW,
        input logic [31:0] aluResultE
    );
        return pcSrcW ? resultW : aluResultE;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with synchronous clear (priority) and enable.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcPlus8,
    input  logic        i_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcPlus8,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pcPlus8;
    logic        r_valid;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_instr   <= NOP_INSTR;
            r_pcPlus8 <= '0;
            r_valid   <= 1'b0;
        end else if (i_enable) begin
            r_instr   <= i_instr;
            r_pcPlus8 <= i_pcPlus8;
            r_valid   <= i_valid;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcPlus8 = r_pcPlus8;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect FSM, imem handshake and IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_StallF,
    input  logic        i_StallD,
    input  logic        i_FlushD,
    input  logic        i_BranchTakenE,
    input  logic [31:0] i_ALUResultE,
    input  logic        i_PCSrcW,
    input  logic [31:0] i_ResultW,
    input  logic        i_ImemRdyF,
    input  logic [31:0] i_ImemInstrF,
    output logic        o_ImemReqF,
    output logic [31:0] o_ImemAddrF,
    output logic [31:0] o_PCF,
    output logic        o_FetchBusyF,
    output logic [31:0] o_InstrD,
    output logic [31:0] o_PCPlus8D,
    output logic        o_ValidD
);

    fetch_state_t r_state;
    logic [31:0]  r_pcF;
    logic [31:0]  r_pendTarget;

    fetch_state_t w_stateNext;
    logic [31:0]  w_pcNext;
    logic [31:0]  w_pendNext;
    logic         w_redir;
    logic [31:0]  w_target;
    logic         w_goodFetch;
    logic [31:0]  w_fetchInstr;

    assign w_redir  = i_PCSrcW | i_BranchTakenE;
    assign w_target = redirTarget(i_PCSrcW, i_ResultW, i_ALUResultE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= RUN;
            r_pcF        <= RESET_PC;
            r_pendTarget <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_pcF        <= w_pcNext;
            r_pendTarget <= w_pendNext;
        end
    end

    // The address must stay put while a fetch is outstanding, so a redirect
    // arriving mid-wait is parked and applied once the stale word returns.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pcF;
        w_pendNext  = r_pendTarget;
        case (r_state)
            RUN: begin
                if (i_ImemRdyF) begin
                    if (w_redir) begin
                        w_pcNext = w_target;
                    end else if (!i_StallF) begin
                        w_pcNext = r_pcF + PC_INC;
                    end
                end else if (w_redir) begin
                    w_pendNext  = w_target;
                    w_stateNext = WAIT_REDIR;
                end
            end
            WAIT_REDIR: begin
                if (w_redir) begin
                    w_pendNext = w_target;
                end
                if (i_ImemRdyF) begin
                    w_pcNext    = w_redir ? w_target : r_pendTarget;
                    w_stateNext = RUN;
                end
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    always_comb begin
        o_ImemReqF   = ~i_reset;
        o_ImemAddrF  = r_pcF;
        o_PCF        = r_pcF;
        o_FetchBusyF = o_ImemReqF & ~i_ImemRdyF;
        w_goodFetch  = i_ImemRdyF & (r_state == RUN) & ~w_redir;
        w_fetchInstr = w_goodFetch ? i_ImemInstrF : NOP_INSTR;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifIdReg (
        .i_clk     (i_clk),
        .i_clear   (i_reset | i_FlushD),
        .i_enable  (~i_StallD),
        .i_instr   (w_fetchInstr),
        .i_pcPlus8 (r_pcF + PC_R15_OFS),
        .i_valid   (w_goodFetch),
        .o_instr   (o_InstrD),
        .o_pcPlus8 (o_PCPlus8D),
        .o_valid   (o_ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus reset sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        reset;
    logic        stallF, stallD, flushD;
    logic        branchTakenE;
    logic [31:0] aluResultE;
    logic        pcSrcW;
    logic [31:0] resultW;
    logic        imemRdyF;
    logic [31:0] imemInstrF;
    logic        imemReqF;
    logic [31:0] imemAddrF;
    logic [31:0] pcF;
    logic        fetchBusyF;
    logic [31:0] instrD;
    logic [31:0] pcPlus8D;
    logic        validD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stallF, stallD, flushD, br, pcSrc, rdy;
        logic [31:0] alu, res, instr;
        logic [31:0] expPCF;
        logic        expBusy;
        logic [31:0] expInstrD, expP8;
        logic        expValid;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_StallF       (stallF),
        .i_StallD       (stallD),
        .i_FlushD       (flushD),
        .i_BranchTakenE (branchTakenE),
        .i_ALUResultE   (aluResultE),
        .i_PCSrcW       (pcSrcW),
        .i_ResultW      (resultW),
        .i_ImemRdyF     (imemRdyF),
        .i_ImemInstrF   (imemInstrF),
        .o_ImemReqF     (imemReqF),
        .o_ImemAddrF    (imemAddrF),
        .o_PCF          (pcF),
        .o_FetchBusyF   (fetchBusyF),
        .o_InstrD       (instrD),
        .o_PCPlus8D     (pcPlus8D),
        .o_ValidD       (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic sF, input logic sD, input logic fD,
                          input logic br, input logic [31:0] alu,
                          input logic pS, input logic [31:0] res,
                          input logic rdy, input logic [31:0] instr,
                          input logic [31:0] ePC, input logic eBusy,
                          input logic [31:0] eInstr, input logic [31:0] eP8,
                          input logic eValid);
        vec_t v;
        v.stallF = sF; v.stallD = sD; v.flushD = fD; v.br = br; v.alu = alu;
        v.pcSrc = pS; v.res = res; v.rdy = rdy; v.instr = instr;
        v.expPCF = ePC; v.expBusy = eBusy; v.expInstrD = eInstr;
        v.expP8 = eP8; v.expValid = eValid;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d actual %h expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stallF       = v.stallF;
        stallD       = v.stallD;
        flushD       = v.flushD;
        branchTakenE = v.br;
        aluResultE   = v.alu;
        pcSrcW       = v.pcSrc;
        resultW      = v.res;
        imemRdyF     = v.rdy;
        imemInstrF   = v.instr;
    endtask

    task automatic idleInputs();
        stallF = 0; stallD = 0; flushD = 0; branchTakenE = 0; aluResultE = '0;
        pcSrcW = 0; resultW = '0; imemRdyF = 1; imemInstrF = 32'h0BAD_F00D;
    endtask

    // One reset cycle: request must drop, then IF/ID and PC return to reset values.
    task automatic resetCycle(input int idx);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("ImemReqF_rst", idx, {31'd0, imemReqF}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("PCF_rst", idx, pcF, 32'h0);
        checkOutput("InstrD_rst", idx, instrD, NOP);
        checkOutput("PCPlus8D_rst", idx, pcPlus8D, 32'h0);
        checkOutput("ValidD_rst", idx, {31'd0, validD}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();

        // sF sD fD br alu            pS res          rdy instr            expPC          busy expInstr        expP8          v
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h1111_0000, 32'h0000_0000, 0, 32'h1111_0000, 32'h0000_0008, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h1111_0001, 32'h0000_0004, 0, 32'h1111_0001, 32'h0000_000C, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h1111_0002, 32'h0000_0008, 0, 32'h1111_0002, 32'h0000_0010, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h1111_0003, 32'h0000_000C, 0, 32'h1111_0003, 32'h0000_0014, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0010, 1, NOP,           32'h0000_0018, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0010, 1, NOP,           32'h0000_0018, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0010, 1, NOP,           32'h0000_0018, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h2222_0004, 32'h0000_0010, 0, 32'h2222_0004, 32'h0000_0018, 1);
        addVec(0,0,0, 1,32'h100,      0,32'h0,        1,32'h2222_0005, 32'h0000_0014, 0, NOP,           32'h0000_001C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h3333_0006, 32'h0000_0100, 0, 32'h3333_0006, 32'h0000_0108, 1);
        addVec(0,0,0, 1,32'h200,      0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0104, 1, NOP,           32'h0000_010C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0104, 1, NOP,           32'h0000_010C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'hBAD0_BAD0, 32'h0000_0104, 0, NOP,           32'h0000_010C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h4444_0007, 32'h0000_0200, 0, 32'h4444_0007, 32'h0000_0208, 1);
        addVec(0,0,0, 1,32'h100,      1,32'h300,      1,32'h4444_0008, 32'h0000_0204, 0, NOP,           32'h0000_020C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h5555_0009, 32'h0000_0300, 0, 32'h5555_0009, 32'h0000_0308, 1);
        addVec(0,1,1, 0,32'h0,        0,32'h0,        1,32'h5555_000A, 32'h0000_0304, 0, NOP,           32'h0000_0000, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h5555_000B, 32'h0000_0308, 0, 32'h5555_000B, 32'h0000_0310, 1);
        addVec(1,1,0, 0,32'h0,        0,32'h0,        1,32'h6666_000C, 32'h0000_030C, 0, 32'h5555_000B, 32'h0000_0310, 1);
        addVec(1,1,0, 0,32'h0,        0,32'h0,        1,32'h6666_000C, 32'h0000_030C, 0, 32'h5555_000B, 32'h0000_0310, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h6666_000D, 32'h0000_030C, 0, 32'h6666_000D, 32'h0000_0314, 1);
        addVec(0,0,0, 1,32'h400,      0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0310, 1, NOP,           32'h0000_0318, 0);
        addVec(0,0,0, 0,32'h0,        1,32'h500,      0,32'hDEAD_BEEF, 32'h0000_0310, 1, NOP,           32'h0000_0318, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'hBAD0_BAD1, 32'h0000_0310, 0, NOP,           32'h0000_0318, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h7777_000E, 32'h0000_0500, 0, 32'h7777_000E, 32'h0000_0508, 1);
        addVec(0,0,0, 1,32'h600,      0,32'h0,        0,32'hDEAD_BEEF, 32'h0000_0504, 1, NOP,           32'h0000_050C, 0);
        addVec(0,0,0, 1,32'h700,      0,32'h0,        1,32'hBAD0_BAD2, 32'h0000_0504, 0, NOP,           32'h0000_050C, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h8888_000F, 32'h0000_0700, 0, 32'h8888_000F, 32'h0000_0708, 1);
        addVec(1,0,0, 0,32'h0,        0,32'h0,        1,32'h8888_0010, 32'h0000_0704, 0, 32'h8888_0010, 32'h0000_070C, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h8888_0011, 32'h0000_0704, 0, 32'h8888_0011, 32'h0000_070C, 1);
        addVec(0,1,0, 0,32'h0,        0,32'h0,        1,32'h8888_0012, 32'h0000_0708, 0, 32'h8888_0011, 32'h0000_070C, 1);
        addVec(0,0,0, 1,32'hFFFF_FFFC,0,32'h0,        1,32'h9999_0013, 32'h0000_070C, 0, NOP,           32'h0000_0714, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h9999_0014, 32'hFFFF_FFFC, 0, 32'h9999_0014, 32'h0000_0004, 1);
        addVec(0,0,0, 1,32'h103,      0,32'h0,        1,32'h9999_0015, 32'h0000_0000, 0, NOP,           32'h0000_0008, 0);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h9999_0016, 32'h0000_0103, 0, 32'h9999_0016, 32'h0000_010B, 1);
        addVec(0,0,0, 0,32'h0,        0,32'h0,        1,32'h9999_0017, 32'h0000_0107, 0, 32'h9999_0017, 32'h0000_010F, 1);

        resetCycle(-2);
        resetCycle(-1);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput("PCF", i, pcF, vecs[i].expPCF);
            checkOutput("ImemAddrF", i, imemAddrF, vecs[i].expPCF);
            checkOutput("ImemReqF", i, {31'd0, imemReqF}, 32'd1);
            checkOutput("FetchBusyF", i, {31'd0, fetchBusyF}, {31'd0, vecs[i].expBusy});
            @(posedge clk);
            #1;
            checkOutput("InstrD", i, instrD, vecs[i].expInstrD);
            checkOutput("PCPlus8D", i, pcPlus8D, vecs[i].expP8);
            checkOutput("ValidD", i, {31'd0, validD}, {31'd0, vecs[i].expValid});
        end

        // Enter WAIT_REDIR with a pending target, then reset: both must be abandoned.
        @(negedge clk);
        idleInputs();
        imemRdyF = 1'b0;
        branchTakenE = 1'b1;
        aluResultE = 32'h800;
        @(posedge clk);
        idleInputs();
        resetCycle(100);
        @(negedge clk);
        reset = 1'b0;
        idleInputs();
        imemInstrF = 32'hCAFE_0001;
        #1;
        checkOutput("PCF_postrst", 101, pcF, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("InstrD_postrst", 101, instrD, 32'hCAFE_0001);
        checkOutput("PCPlus8D_postrst", 101, pcPlus8D, 32'h8);
        checkOutput("ValidD_postrst", 101, {31'd0, validD}, 32'd1);
        checkOutput("PCF_afterfetch", 101, pcF, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined ARM core, directly upstream of the decode stage.
- Owns the PC register and next-PC selection, and drives the instruction-memory request/ready handshake.
- Contains the IF/ID pipeline register that produces InstrD, PCPlus8D and ValidD for decode.
- Responds to hazard-unit stall/flush and to PC redirects from execute (branch) and writeback (write to R15).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'hE1A0_0000, MOV r0,r0; driven on InstrD for any bubble.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
StallF  input  1  hazard unit: hold PC.
StallD  input  1  hazard unit: hold IF/ID register.
FlushD  input  1  hazard unit: bubble IF/ID register.
BranchTakenE  input  1  taken branch resolved in execute.
ALUResultE  input  32  branch target.
PCSrcW  input  1  writeback instruction writes R15.
ResultW  input  32  R15 write value.
ImemRdyF  input  1  ImemInstrF valid for ImemAddrF this cycle.
ImemInstrF  input  32  instruction word from memory.
ImemReqF  output  1  fetch request.
ImemAddrF  output  32  fetch address, equal to PCF.
PCF  output  32  current fetch PC.
FetchBusyF  output  1  request outstanding and not ready; hazard unit uses it to stall.
InstrD  output  32  instruction to decode.
PCPlus8D  output  32  PC of InstrD plus 8; R15 read value.
ValidD  output  1  InstrD is a real instruction.

Behaviour:
- Reset, applied for one or more cycles:
  - PCF = RESET_PC.
  - state = RUN; pending-target register = 0.
  - InstrD = NOP_INSTR, PCPlus8D = 0, ValidD = 0.
  - ImemReqF = 0 during reset; = 1 in every other cycle.
  - A reset mid-wait abandons the outstanding fetch and any pending redirect.
- Handshake:
  - ImemAddrF must stay stable while ImemReqF=1 and ImemRdyF=0.
  - A fetch completes in the cycle ImemRdyF=1.
  - Zero-wait memory means 1 instruction per cycle.
- Redirect:
  - redir = PCSrcW | BranchTakenE.
  - Target = ResultW if PCSrcW, else ALUResultE; PCSrcW has priority.
- FSM states RUN and WAIT_REDIR:
  - RUN, ImemRdyF=1:
    - if redir, PCF <= target;
    - else if !StallF, PCF <= PCF+4;
    - else PCF holds.
  - RUN, ImemRdyF=0, redir: latch target into the pending register, PCF holds, go to WAIT_REDIR.
  - RUN, ImemRdyF=0, no redir: stay in RUN, PCF holds.
  - WAIT_REDIR:
    - ImemAddrF stays at the stale PCF.
    - A new redir overwrites the pending target.
    - On ImemRdyF=1: discard the word; PCF <= the new target if redir is asserted this cycle, else the pending target; go to RUN.
- Redirect overrides StallF.
- FetchBusyF = ImemReqF & !ImemRdyF.
- IF/ID register, in priority order:
  1. reset;
  2. FlushD: InstrD = NOP_INSTR, ValidD = 0, PCPlus8D = 0;
  3. StallD: hold all fields;
  4. otherwise load:
     - InstrD = ImemInstrF if the fetch is good, else NOP_INSTR;
     - PCPlus8D = PCF + 8 (32-bit, wraps modulo 2^32);
     - ValidD = good fetch.
- Good fetch = ImemRdyF & state==RUN & !redir. The wrong-path word in the redirect cycle becomes a bubble even without FlushD.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. Targets are not realigned; bits [1:0] pass through.
- StallF=1 with StallD=0 is legal: decode receives the same PC again as a duplicate. The hazard unit never does this for real hazards.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic {RUN, WAIT_REDIR} fetch_state_t;
  - localparam NOP_INSTR_DEF = 32'hE1A0_0000;
  - localparam PC_INC = 4 and PC_R15_OFS = 8.
- Sub-module if_id_reg: enable/clear pipeline register for {InstrD, PCPlus8D, ValidD}. Clear has priority over enable.
- The FSM and next-PC logic stay in fetch_stage.

Test Plan:
- Reset then ImemRdyF=1 constant → PCF: 0, 4, 8, C. ValidD rises 1 cycle after reset release; PCPlus8D = 8, C, 10.
- ImemRdyF low for 3 cycles at PCF=0x10 → ImemAddrF held at 0x10, FetchBusyF=1, ValidD=0 into decode; PCF advances to 0x14 after ready.
- BranchTakenE=1 with ALUResultE=0x100 while ready → next PCF=0x100; same-cycle word becomes a bubble (ValidD=0, InstrD=E1A00000).
- Redirect to 0x200 while not ready, then ready 2 cycles later → stale word discarded, PCF=0x200, state returns to RUN.
- PCSrcW (ResultW=0x300) and BranchTakenE (0x100) together → PCF=0x300.
- StallD and FlushD together → bubble loaded. StallF+StallD for 2 cycles → PCF and InstrD held. Assert reset in WAIT_REDIR → PCF=RESET_PC, ValidD=0.
